// File: rtl/cve2_lsu_obi.sv
// Load/store unit with a single-outstanding OBI data port and sign/zero-extended load return.
// Define CVE2_LSU_MISALIGNED_EN to split misaligned accesses into two aligned beats; otherwise they are rejected.
module cve2_lsu_obi (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [31:0] adder_result_ex_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_resp_valid_o,
    output logic        load_err_o,
    output logic        store_err_o,
    output logic        misaligned_err_o,
    output logic        busy_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] GNT0 = 3'd1;
    localparam logic [2:0] RV0  = 3'd2;
`ifdef CVE2_LSU_MISALIGNED_EN
    localparam logic [2:0] GNT1 = 3'd3;
    localparam logic [2:0] RV1  = 3'd4;
`else
    localparam logic [2:0] MERR = 3'd5;
`endif

    function automatic logic [3:0] be_beat(input logic [1:0] typ, input logic [1:0] off,
                                           input logic hi);
        logic [7:0] wide;
        case (typ)
            2'b01:   wide = 8'h03;
            2'b10:   wide = 8'h01;
            default: wide = 8'h0F;
        endcase
        wide = wide << off;
        return hi ? wide[7:4] : wide[3:0];
    endfunction

    function automatic logic is_split(input logic [1:0] typ, input logic [1:0] off);
        if (typ == 2'b01)
            return off == 2'd3;
        else if (typ == 2'b10)
            return 1'b0;
        else
            return off != 2'd0;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] d, input logic [1:0] off);
        case (off)
            2'd1:    return {d[23:0], d[31:24]};
            2'd2:    return {d[15:0], d[31:16]};
            2'd3:    return {d[7:0], d[31:8]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] d, input logic [1:0] off);
        case (off)
            2'd1:    return {d[7:0], d[31:8]};
            2'd2:    return {d[15:0], d[31:16]};
            2'd3:    return {d[23:0], d[31:24]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] typ,
                                           input logic sext);
        case (typ)
            2'b01:   return sext ? {{16{d[15]}}, d[15:0]} : {16'h0000, d[15:0]};
            2'b10:   return sext ? {{24{d[7]}}, d[7:0]} : {24'h000000, d[7:0]};
            default: return d;
        endcase
    endfunction

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q;
    logic [1:0]  type_q;
    logic        sign_ext_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic        accept;
    logic        complete;
    logic [31:0] resp_raw;
    logic [31:0] beat0_addr;
    logic        rv_state;

    assign beat0_addr = {addr_q[31:2], 2'b00};

`ifdef CVE2_LSU_MISALIGNED_EN
    logic [31:0] rdata_q;
    logic        capture;
    logic        split_q;
    logic [31:0] assembled;

    assign split_q  = is_split(type_q, addr_q[1:0]);
    assign rv_state = (state_q == RV0) || (state_q == RV1);

    // Lanes at or above the offset came back with beat 0, the rest with beat 1.
    always_comb begin
        assembled = data_rdata_i;
        for (int i = 0; i < 4; i++) begin
            if (i >= int'(addr_q[1:0]))
                assembled[8*i +: 8] = rdata_q[8*i +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            rdata_q <= '0;
        else if (capture)
            rdata_q <= data_rdata_i;
    end
`else
    logic split_live;

    assign split_live = is_split(lsu_type_i, adder_result_ex_i[1:0]);
    assign rv_state   = (state_q == RV0);
`endif

    always_comb begin
        state_d          = state_q;
        accept           = 1'b0;
        complete         = 1'b0;
        resp_raw         = data_rdata_i;
        data_req_o       = 1'b0;
        data_addr_o      = '0;
        data_be_o        = '0;
        data_we_o        = 1'b0;
        data_wdata_o     = '0;
        lsu_resp_valid_o = 1'b0;
        lsu_rdata_o      = '0;
        load_err_o       = 1'b0;
        store_err_o      = 1'b0;
        misaligned_err_o = 1'b0;
`ifdef CVE2_LSU_MISALIGNED_EN
        capture          = 1'b0;
`endif
        // Everything is held quiet while reset is asserted, including new acceptances.
        if (rst_ni) begin
            case (state_q)
                IDLE: begin
                    if (lsu_req_i) begin
                        accept       = 1'b1;
                        data_req_o   = 1'b1;
                        data_addr_o  = {adder_result_ex_i[31:2], 2'b00};
                        data_be_o    = be_beat(lsu_type_i, adder_result_ex_i[1:0], 1'b0);
                        data_we_o    = lsu_we_i;
                        data_wdata_o = rotl(lsu_wdata_i, adder_result_ex_i[1:0]);
                        state_d      = data_gnt_i ? RV0 : GNT0;
`ifndef CVE2_LSU_MISALIGNED_EN
                        if (split_live) begin
                            data_req_o   = 1'b0;
                            data_addr_o  = '0;
                            data_be_o    = '0;
                            data_we_o    = 1'b0;
                            data_wdata_o = '0;
                            state_d      = MERR;
                        end
`endif
                    end
                end
                GNT0: begin
                    data_req_o   = 1'b1;
                    data_addr_o  = beat0_addr;
                    data_be_o    = be_beat(type_q, addr_q[1:0], 1'b0);
                    data_we_o    = we_q;
                    data_wdata_o = wdata_q;
                    if (data_gnt_i)
                        state_d = RV0;
                end
                RV0: begin
                    if (data_rvalid_i) begin
`ifdef CVE2_LSU_MISALIGNED_EN
                        if (split_q && !data_err_i) begin
                            capture      = 1'b1;
                            data_req_o   = 1'b1;
                            data_addr_o  = beat0_addr + 32'd4;
                            data_be_o    = be_beat(type_q, addr_q[1:0], 1'b1);
                            data_we_o    = we_q;
                            data_wdata_o = wdata_q;
                            state_d      = data_gnt_i ? RV1 : GNT1;
                        end else begin
                            complete = 1'b1;
                            state_d  = IDLE;
                        end
`else
                        complete = 1'b1;
                        state_d  = IDLE;
`endif
                    end
                end
`ifdef CVE2_LSU_MISALIGNED_EN
                GNT1: begin
                    data_req_o   = 1'b1;
                    data_addr_o  = beat0_addr + 32'd4;
                    data_be_o    = be_beat(type_q, addr_q[1:0], 1'b1);
                    data_we_o    = we_q;
                    data_wdata_o = wdata_q;
                    if (data_gnt_i)
                        state_d = RV1;
                end
                RV1: begin
                    resp_raw = assembled;
                    if (data_rvalid_i) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end
                end
`else
                MERR: begin
                    lsu_resp_valid_o = 1'b1;
                    misaligned_err_o = 1'b1;
                    state_d          = IDLE;
                end
`endif
                default: state_d = IDLE;
            endcase

            if (complete) begin
                lsu_resp_valid_o = 1'b1;
                if (data_err_i) begin
                    load_err_o  = ~we_q;
                    store_err_o = we_q;
                end else begin
                    lsu_rdata_o = extend(rotr(resp_raw, addr_q[1:0]), type_q, sign_ext_q);
                end
            end
        end
    end

    assign busy_o = rst_ni && (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            type_q     <= '0;
            sign_ext_q <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q     <= adder_result_ex_i;
                type_q     <= lsu_type_i;
                sign_ext_q <= lsu_sign_ext_i;
                we_q       <= lsu_we_i;
                wdata_q    <= rotl(lsu_wdata_i, adder_result_ex_i[1:0]);
            end
        end
    end

    // A response is only legal while a granted beat is outstanding.
    assert property (@(posedge clk_i) disable iff (!rst_ni) data_rvalid_i |-> rv_state);

endmodule

// File: tb/tb_cve2_lsu_obi.sv
// Directed testbench for cve2_lsu_obi: table of single-beat accesses plus hand-written
// sequences for stalls, reset, and (depending on CVE2_LSU_MISALIGNED_EN) split or rejected accesses.
module tb_cve2_lsu_obi;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        lsu_req_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [1:0]  lsu_type_i = 2'b00;
    logic        lsu_sign_ext_i = 1'b0;
    logic [31:0] lsu_wdata_i = '0;
    logic [31:0] adder_result_ex_i = '0;
    logic [31:0] lsu_rdata_o;
    logic        lsu_resp_valid_o;
    logic        load_err_o;
    logic        store_err_o;
    logic        misaligned_err_o;
    logic        busy_o;
    logic        data_req_o;
    logic        data_gnt_i = 1'b0;
    logic        data_rvalid_i = 1'b0;
    logic        data_err_i = 1'b0;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i = '0;

    int assertions = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [1:0]  typ;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs[NVEC];

    cve2_lsu_obi dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .lsu_req_i         (lsu_req_i),
        .lsu_we_i          (lsu_we_i),
        .lsu_type_i        (lsu_type_i),
        .lsu_sign_ext_i    (lsu_sign_ext_i),
        .lsu_wdata_i       (lsu_wdata_i),
        .adder_result_ex_i (adder_result_ex_i),
        .lsu_rdata_o       (lsu_rdata_o),
        .lsu_resp_valid_o  (lsu_resp_valid_o),
        .load_err_o        (load_err_o),
        .store_err_o       (store_err_o),
        .misaligned_err_o  (misaligned_err_o),
        .busy_o            (busy_o),
        .data_req_o        (data_req_o),
        .data_gnt_i        (data_gnt_i),
        .data_rvalid_i     (data_rvalid_i),
        .data_err_i        (data_err_i),
        .data_addr_o       (data_addr_o),
        .data_we_o         (data_we_o),
        .data_be_o         (data_be_o),
        .data_wdata_o      (data_wdata_o),
        .data_rdata_i      (data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic startCycle();
        @(posedge clk_i);
        #1;
    endtask

    // Zero-wait single-beat access; the request is held during the response cycle to
    // confirm nothing new is accepted until the FSM is back in IDLE.
    task automatic applyStimulus(input vec_t v, input int idx);
        startCycle();
        lsu_req_i         = 1'b1;
        lsu_we_i          = v.we;
        lsu_type_i        = v.typ;
        lsu_sign_ext_i    = v.sext;
        lsu_wdata_i       = v.wdata;
        adder_result_ex_i = v.addr;
        data_gnt_i        = 1'b1;
        @(negedge clk_i);
        checkOutput($sformatf("v%0d req", idx), 32'(data_req_o), 32'd1);
        checkOutput($sformatf("v%0d addr", idx), data_addr_o, v.exp_addr);
        checkOutput($sformatf("v%0d be", idx), 32'(data_be_o), 32'(v.exp_be));
        checkOutput($sformatf("v%0d we", idx), 32'(data_we_o), 32'(v.we));
        checkOutput($sformatf("v%0d wdata", idx), data_wdata_o, v.exp_wdata);
        checkOutput($sformatf("v%0d early resp", idx), 32'(lsu_resp_valid_o), 32'd0);
        startCycle();
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = v.rdata;
        data_err_i    = v.err;
        @(negedge clk_i);
        checkOutput($sformatf("v%0d resp", idx), 32'(lsu_resp_valid_o), 32'd1);
        checkOutput($sformatf("v%0d rdata", idx), lsu_rdata_o, v.exp_rdata);
        checkOutput($sformatf("v%0d load_err", idx), 32'(load_err_o), 32'(v.err & ~v.we));
        checkOutput($sformatf("v%0d store_err", idx), 32'(store_err_o), 32'(v.err & v.we));
        checkOutput($sformatf("v%0d misaligned", idx), 32'(misaligned_err_o), 32'd0);
        checkOutput($sformatf("v%0d no accept in resp", idx), 32'(data_req_o), 32'd0);
        checkOutput($sformatf("v%0d busy", idx), 32'(busy_o), 32'd1);
        startCycle();
        lsu_req_i     = 1'b0;
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        data_rdata_i  = '0;
        @(negedge clk_i);
        checkOutput($sformatf("v%0d idle resp", idx), 32'(lsu_resp_valid_o), 32'd0);
        checkOutput($sformatf("v%0d idle busy", idx), 32'(busy_o), 32'd0);
    endtask

    // Called right after an edge while a request is pending; the late response arrives under reset.
    task automatic resetMidOp(input string tag);
        rst_ni     = 1'b0;
        data_gnt_i = 1'b0;
        @(negedge clk_i);
        checkOutput({tag, " req in reset"}, 32'(data_req_o), 32'd0);
        startCycle();
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h12345678;
        @(negedge clk_i);
        checkOutput({tag, " late rvalid resp"}, 32'(lsu_resp_valid_o), 32'd0);
        startCycle();
        rst_ni        = 1'b1;
        data_rvalid_i = 1'b0;
        data_rdata_i  = '0;
        @(negedge clk_i);
        checkOutput({tag, " busy after reset"}, 32'(busy_o), 32'd0);
        checkOutput({tag, " req after reset"}, 32'(data_req_o), 32'd0);
        checkOutput({tag, " resp after reset"}, 32'(lsu_resp_valid_o), 32'd0);
    endtask

`ifndef CVE2_LSU_MISALIGNED_EN
    task automatic rejectSeq(input logic [31:0] addr, input logic [1:0] typ, input string tag);
        startCycle();
        lsu_req_i         = 1'b1;
        lsu_we_i          = 1'b0;
        lsu_type_i        = typ;
        adder_result_ex_i = addr;
        data_gnt_i        = 1'b1;
        @(negedge clk_i);
        checkOutput({tag, " req"}, 32'(data_req_o), 32'd0);
        checkOutput({tag, " early misaligned"}, 32'(misaligned_err_o), 32'd0);
        checkOutput({tag, " early resp"}, 32'(lsu_resp_valid_o), 32'd0);
        startCycle();
        lsu_type_i        = 2'b00;
        adder_result_ex_i = 32'h0000_0200;
        @(negedge clk_i);
        checkOutput({tag, " misaligned"}, 32'(misaligned_err_o), 32'd1);
        checkOutput({tag, " resp"}, 32'(lsu_resp_valid_o), 32'd1);
        checkOutput({tag, " load_err"}, 32'(load_err_o), 32'd0);
        checkOutput({tag, " no accept in resp"}, 32'(data_req_o), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy_o), 32'd1);
        startCycle();
        lsu_req_i  = 1'b0;
        data_gnt_i = 1'b0;
        @(negedge clk_i);
        checkOutput({tag, " misaligned after"}, 32'(misaligned_err_o), 32'd0);
        checkOutput({tag, " busy after"}, 32'(busy_o), 32'd0);
    endtask
`endif

    initial begin
        //               we    typ    sext  addr          wdata         rdata         err   exp_addr      be     exp_wdata     exp_rdata
        vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 1'b0, 32'h0000_0100, 4'hF, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{1'b0, 2'b10, 1'b1, 32'h0000_0103, 32'h0,        32'h8012_3456, 1'b0, 32'h0000_0100, 4'h8, 32'h0,       32'hFFFF_FF80};
        vecs[2]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0103, 32'h0,        32'h8012_3456, 1'b0, 32'h0000_0100, 4'h8, 32'h0,       32'h0000_0080};
        vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0,        32'h8001_1234, 1'b0, 32'h0000_0100, 4'hC, 32'h0,       32'hFFFF_8001};
        vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0,        32'h12AB_CD34, 1'b0, 32'h0000_0100, 4'h6, 32'h0,       32'h0000_ABCD};
        vecs[5]  = '{1'b0, 2'b10, 1'b1, 32'h0000_0101, 32'h0,        32'h0000_FF00, 1'b0, 32'h0000_0100, 4'h2, 32'h0,       32'hFFFF_FFFF};
        vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0,        32'h1234_56F0, 1'b0, 32'h0000_0200, 4'h1, 32'h0,       32'h0000_00F0};
        vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h0000_00A5, 32'h0,       1'b0, 32'h0000_0100, 4'h4, 32'h00A5_0000, 32'h0};
        vecs[8]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0200, 32'h1122_3344, 32'h0,       1'b0, 32'h0000_0200, 4'hF, 32'h1122_3344, 32'h0};
        vecs[9]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0201, 32'h0000_BEEF, 32'h0,       1'b0, 32'h0000_0200, 4'h6, 32'h00BE_EF00, 32'h0};
        vecs[10] = '{1'b0, 2'b00, 1'b0, 32'h0000_0300, 32'h0,        32'h5555_5555, 1'b1, 32'h0000_0300, 4'hF, 32'h0,       32'h0};
        vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h0000_0306, 32'h0000_1234, 32'h7777_7777, 1'b1, 32'h0000_0304, 4'hC, 32'h1234_0000, 32'h0};
        vecs[12] = '{1'b0, 2'b11, 1'b0, 32'h0000_0400, 32'h0,        32'hCAFE_F00D, 1'b0, 32'h0000_0400, 4'hF, 32'h0,       32'hCAFE_F00D};
        vecs[13] = '{1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0,        32'h0000_7FFF, 1'b0, 32'h0000_0100, 4'h3, 32'h0,       32'h0000_7FFF};

        // Reset with a live request: nothing may escape.
        lsu_req_i         = 1'b1;
        adder_result_ex_i = 32'h0000_0100;
        data_gnt_i        = 1'b1;
        @(negedge clk_i);
        checkOutput("reset req", 32'(data_req_o), 32'd0);
        checkOutput("reset addr", data_addr_o, 32'd0);
        checkOutput("reset busy", 32'(busy_o), 32'd0);
        checkOutput("reset resp", 32'(lsu_resp_valid_o), 32'd0);
        startCycle();
        lsu_req_i  = 1'b0;
        data_gnt_i = 1'b0;
        rst_ni     = 1'b1;
        @(negedge clk_i);
        checkOutput("post reset busy", 32'(busy_o), 32'd0);

        for (int i = 0; i < NVEC; i++)
            applyStimulus(vecs[i], i);

        // Grant stalled three cycles; live inputs change but the bus must stay put.
        startCycle();
        lsu_req_i         = 1'b1;
        lsu_we_i          = 1'b0;
        lsu_type_i        = 2'b00;
        lsu_sign_ext_i    = 1'b0;
        adder_result_ex_i = 32'h0000_0500;
        data_gnt_i        = 1'b0;
        @(negedge clk_i);
        checkOutput("stall c0 addr", data_addr_o, 32'h0000_0500);
        for (int i = 0; i < 3; i++) begin
            startCycle();
            lsu_req_i         = 1'b0;
            adder_result_ex_i = 32'hFFFF_FF03;
            lsu_type_i        = 2'b10;
            data_gnt_i        = (i == 2);
            @(negedge clk_i);
            checkOutput($sformatf("stall c%0d req", i + 1), 32'(data_req_o), 32'd1);
            checkOutput($sformatf("stall c%0d addr", i + 1), data_addr_o, 32'h0000_0500);
            checkOutput($sformatf("stall c%0d be", i + 1), 32'(data_be_o), 32'hF);
            checkOutput($sformatf("stall c%0d resp", i + 1), 32'(lsu_resp_valid_o), 32'd0);
        end
        startCycle();
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h0102_0304;
        @(negedge clk_i);
        checkOutput("stall resp", 32'(lsu_resp_valid_o), 32'd1);
        checkOutput("stall rdata", lsu_rdata_o, 32'h0102_0304);
        startCycle();
        data_rvalid_i = 1'b0;
        data_rdata_i  = '0;

`ifdef CVE2_LSU_MISALIGNED_EN
        // Split word store at 0x102.
        startCycle();
        lsu_req_i         = 1'b1;
        lsu_we_i          = 1'b1;
        lsu_type_i        = 2'b00;
        lsu_wdata_i       = 32'h1122_3344;
        adder_result_ex_i = 32'h0000_0102;
        data_gnt_i        = 1'b1;
        @(negedge clk_i);
        checkOutput("sst b0 addr", data_addr_o, 32'h0000_0100);
        checkOutput("sst b0 be", 32'(data_be_o), 32'hC);
        checkOutput("sst b0 wdata", data_wdata_o, 32'h3344_1122);
        startCycle();
        lsu_req_i     = 1'b0;
        data_rvalid_i = 1'b1;
        @(negedge clk_i);
        checkOutput("sst b1 req", 32'(data_req_o), 32'd1);
        checkOutput("sst b1 addr", data_addr_o, 32'h0000_0104);
        checkOutput("sst b1 be", 32'(data_be_o), 32'h3);
        checkOutput("sst b1 wdata", data_wdata_o, 32'h3344_1122);
        checkOutput("sst b1 no resp", 32'(lsu_resp_valid_o), 32'd0);
        startCycle();
        data_gnt_i = 1'b0;
        @(negedge clk_i);
        checkOutput("sst resp", 32'(lsu_resp_valid_o), 32'd1);
        checkOutput("sst store_err", 32'(store_err_o), 32'd0);
        startCycle();
        data_rvalid_i = 1'b0;

        // Split half load wrapping past the top of the address space.
        startCycle();
        lsu_req_i         = 1'b1;
        lsu_we_i          = 1'b0;
        lsu_type_i        = 2'b01;
        lsu_sign_ext_i    = 1'b0;
        adder_result_ex_i = 32'hFFFF_FFFF;
        data_gnt_i        = 1'b1;
        @(negedge clk_i);
        checkOutput("wrap b0 addr", data_addr_o, 32'hFFFF_FFFC);
        checkOutput("wrap b0 be", 32'(data_be_o), 32'h8);
        startCycle();
        lsu_req_i     = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hAB00_0000;
        @(negedge clk_i);
        checkOutput("wrap b1 addr", data_addr_o, 32'h0000_0000);
        checkOutput("wrap b1 be", 32'(data_be_o), 32'h1);
        startCycle();
        data_gnt_i   = 1'b0;
        data_rdata_i = 32'h0000_00CD;
        @(negedge clk_i);
        checkOutput("wrap resp", 32'(lsu_resp_valid_o), 32'd1);
        checkOutput("wrap rdata", lsu_rdata_o, 32'h0000_CDAB);
        startCycle();
        data_rvalid_i = 1'b0;
        data_rdata_i  = '0;

        // Error on beat 0 of a split load suppresses beat 1.
        startCycle();
        lsu_req_i         = 1'b1;
        lsu_type_i        = 2'b00;
        adder_result_ex_i = 32'h0000_0101;
        data_gnt_i        = 1'b1;
        @(negedge clk_i);
        startCycle();
        lsu_req_i     = 1'b0;
        data_rvalid_i = 1'b1;
        data_err_i    = 1'b1;
        data_rdata_i  = 32'h5A5A_5A5A;
        @(negedge clk_i);
        checkOutput("err b0 no req", 32'(data_req_o), 32'd0);
        checkOutput("err b0 resp", 32'(lsu_resp_valid_o), 32'd1);
        checkOutput("err b0 load_err", 32'(load_err_o), 32'd1);
        checkOutput("err b0 rdata", lsu_rdata_o, 32'd0);
        startCycle();
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        data_gnt_i    = 1'b0;
        data_rdata_i  = '0;
        @(negedge clk_i);
        checkOutput("err b0 idle", 32'(busy_o), 32'd0);

        // Reset while waiting for the second grant.
        startCycle();
        lsu_req_i         = 1'b1;
        adder_result_ex_i = 32'h0000_0106;
        data_gnt_i        = 1'b1;
        @(negedge clk_i);
        startCycle();
        lsu_req_i     = 1'b0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b1;
        @(negedge clk_i);
        checkOutput("gnt1 b1 addr", data_addr_o, 32'h0000_0108);
        startCycle();
        data_rvalid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("gnt1 held req", 32'(data_req_o), 32'd1);
        checkOutput("gnt1 held addr", data_addr_o, 32'h0000_0108);
        startCycle();
        resetMidOp("rst gnt1");
`else
        rejectSeq(32'h0000_0101, 2'b00, "rej word");
        rejectSeq(32'h0000_0103, 2'b01, "rej half");

        // Reset while waiting for the first grant.
        startCycle();
        lsu_req_i         = 1'b1;
        lsu_type_i        = 2'b00;
        adder_result_ex_i = 32'h0000_0600;
        data_gnt_i        = 1'b0;
        @(negedge clk_i);
        startCycle();
        lsu_req_i = 1'b0;
        @(negedge clk_i);
        checkOutput("gnt0 held req", 32'(data_req_o), 32'd1);
        startCycle();
        resetMidOp("rst gnt0");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
